// File: rtl/multi_blink_pkg.sv
// rtl/multi_blink_pkg.sv - shared mode encoding for the multi-channel blinker
package multi_blink_pkg;
  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF,
    MODE_ON,
    MODE_BLINK,
    MODE_PULSE
  } blink_mode_t;
endpackage

// File: rtl/multi_blink_chan.sv
// rtl/multi_blink_chan.sv - one blinker channel: mode/period/down-counter, led and wrap flag
// Optional MULTI_BLINK_SYNC_EN adds the sync input that phase-aligns the channel.
module blink_chan
  import multi_blink_pkg::*;
#(
  parameter int               CBITS          = 32,
  parameter logic [CBITS-1:0] DEFAULT_PERIOD = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              run,
`ifdef MULTI_BLINK_SYNC_EN
  input  logic              sync,
`endif
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [CBITS-1:0]  cfg_period,
  output logic              led,
  output logic              flg
);
  blink_mode_t      mode;
  logic [CBITS-1:0] period;
  logic [CBITS-1:0] cnt;
  logic             adv;
  logic             wrap;

  assign adv  = run && (mode == MODE_BLINK || mode == MODE_PULSE);
  assign wrap = adv && (cnt == '0);

  // Priority: reset, then a config write (restarts phase), then sync, then normal run.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode   <= MODE_OFF;
      period <= DEFAULT_PERIOD;
      cnt    <= DEFAULT_PERIOD;
      led    <= 1'b0;
      flg    <= 1'b0;
    end else if (load) begin
      mode   <= blink_mode_t'(cfg_mode);
      period <= cfg_period;
      cnt    <= cfg_period;
      led    <= (blink_mode_t'(cfg_mode) == MODE_ON);
      flg    <= 1'b0;
`ifdef MULTI_BLINK_SYNC_EN
    end else if (sync) begin
      cnt <= period;
      led <= (mode == MODE_ON);
      flg <= 1'b0;
`endif
    end else if (run) begin
      flg <= wrap;
      if (adv) cnt <= wrap ? period : cnt - 1'b1;
      case (mode)
        MODE_OFF:   led <= 1'b0;
        MODE_ON:    led <= 1'b1;
        MODE_BLINK: if (wrap) led <= ~led;
        MODE_PULSE: led <= wrap;
        default:    led <= 1'b0;
      endcase
    end else begin
      flg <= 1'b0;
    end
  end
endmodule

// File: rtl/multi_blink.sv
// rtl/multi_blink.sv - NCH-channel LED/heartbeat generator with a one-cycle config write port
// Optional MULTI_BLINK_SYNC_EN adds a global sync input that restarts every channel's phase.
module multi_blink
  import multi_blink_pkg::*;
#(
  parameter int               NCH            = 4,
  parameter int               CBITS          = 32,
  parameter logic [CBITS-1:0] DEFAULT_PERIOD = CBITS'(2**24 - 1),
  localparam int              CHW            = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef MULTI_BLINK_SYNC_EN
  input  logic              sync,
`endif
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [MODE_W-1:0] cfg_mode,
  input  logic [CBITS-1:0]  cfg_period,
  output logic [NCH-1:0]    led,
  output logic [NCH-1:0]    flg
);
  logic [NCH-1:0] load;

  // Out-of-range channel numbers match no decoder output, so such writes vanish.
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign load[i] = cfg_we && (cfg_ch == CHW'(i));

    blink_chan #(
      .CBITS          (CBITS),
      .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .load       (load[i]),
      .run        (en),
`ifdef MULTI_BLINK_SYNC_EN
      .sync       (sync),
`endif
      .cfg_mode   (cfg_mode),
      .cfg_period (cfg_period),
      .led        (led[i]),
      .flg        (flg[i])
    );
  end
endmodule

// File: tb/tb_multi_blink.sv
// tb/tb_multi_blink.sv - randomized self-checking bench for multi_blink against a wrap-count model
module tb_multi_blink;
  import multi_blink_pkg::*;

  localparam int NCH   = 3;
  localparam int CBITS = 8;
  localparam int DEFP  = 200;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CBITS-1:0] cfg_period;
  logic [NCH-1:0]   led;
  logic [NCH-1:0]   flg;
`ifdef MULTI_BLINK_SYNC_EN
  logic             sync = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Model: per channel, mode, period and number of advancing edges since the last write.
  int             m_mode [NCH];
  int             m_p    [NCH];
  longint         m_k    [NCH];
  logic [NCH-1:0] e_led;
  logic [NCH-1:0] e_flg;

  multi_blink #(
    .NCH            (NCH),
    .CBITS          (CBITS),
    .DEFAULT_PERIOD (8'(DEFP))
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
`ifdef MULTI_BLINK_SYNC_EN
    .sync       (sync),
`endif
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_mode   (cfg_mode),
    .cfg_period (cfg_period),
    .led        (led),
    .flg        (flg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit w;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_mode[i] = 0;
        m_p[i]    = DEFP;
        m_k[i]    = 0;
      end
      e_led = '0;
      e_flg = '0;
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      if (cfg_we && int'(cfg_ch) == i) begin
        m_mode[i] = int'(cfg_mode);
        m_p[i]    = int'(cfg_period);
        m_k[i]    = 0;
        e_flg[i]  = 1'b0;
        e_led[i]  = (cfg_mode == 2'd1);
      end else if (en) begin
        if (m_mode[i] >= 2) begin
          m_k[i]++;
          w        = (m_k[i] % (m_p[i] + 1)) == 0;
          e_flg[i] = w;
          e_led[i] = (m_mode[i] == 2) ? ((m_k[i] / (m_p[i] + 1)) % 2 == 1) : w;
        end else begin
          e_flg[i] = 1'b0;
          e_led[i] = (m_mode[i] == 1);
        end
      end else begin
        e_flg[i] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("led", 32'(led), 32'(e_led));
    check("flg", 32'(flg), 32'(e_flg));
  endtask

  task automatic write(input int ch, input int mode, input int p);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_period = 8'(p);
    step();
    cfg_we     = 1'b0;
  endtask

  initial begin
    int pulses;
    int first;
    rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_period = '0;
    step();
    step();
    check("reset_led", 32'(led), 32'd0);
    check("reset_flg", 32'(flg), 32'd0);
    rst = 1'b0;
    en  = 1'b1;
    for (int c = 0; c < 100; c++) step();

    write(1, 2, 3);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      pulses += int'(flg[1]);
    end
    check("ch1_pulses", 32'(pulses), 32'd5);

    write(2, 3, 0);
    for (int c = 0; c < 5; c++) step();
    en = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("ch2_hold_led", 32'(led[2]), 32'd1);
    en = 1'b1;

    for (int c = 0; c < 4 && (m_k[1] % 4) != 3; c++) step();
    write(1, 2, 5);
    check("ch1_rewrite_flg", 32'(flg[1]), 32'd0);
    first = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (flg[1] && first == 0) first = c;
    end
    check("ch1_rewrite_gap", 32'(first), 32'd6);

    write(0, 1, 4);
    check("ch0_on", 32'(led[0]), 32'd1);
    write(0, 0, 4);
    check("ch0_off", 32'(led[0]), 32'd0);
    write(3, 1, 7);
    for (int c = 0; c < 10; c++) step();

    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0)
        write($urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 9));
      else
        step();
    end

    en = 1'b1;
    write(0, 2, 1);
    step();
    rst = 1'b1;
    step();
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_flg", 32'(flg), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
